cpu_axi_bridge: RTL and testbench

- Sits directly downstream of the CPU core, between its instruction and data SRAM-like request ports and a single AXI3 master port to the SoC interconnect.
- Arbitrates between the two requesters, with data taking priority over instruction.
- Allows one outstanding transaction at a time.
- Converts each accepted request into a single-beat AXI read or write.
- Returns completion to the requester via a one-cycle data_ok pulse.

---
 rtl/cpu_axi_pkg.sv | 33 +++
 rtl/cpu_axi_bridge_if.sv | 75 +++++++
 rtl/axi_wr_tracker.sv | 45 ++++
 rtl/cpu_axi_bridge.sv | 171 +++++++++++++++++
 tb/tb_cpu_axi_bridge.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_axi_pkg.sv
// rtl/cpu_axi_pkg.sv - shared types and constants for the CPU-to-AXI bridge
//
// Purpose: FSM state encoding, request owner enum, fixed AXI field values and
// access size codes used by cpu_axi_bridge and its sub-modules.
// Ports: none (package).
package cpu_axi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_AR   = 3'd1,
    RD_R    = 3'd2,
    WR_AW_W = 3'd3,
    WR_B    = 3'd4
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  localparam logic [3:0] LEN_SINGLE = 4'd0;
  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // The CPU size code maps directly onto AXSIZE for byte/half/word.
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/cpu_axi_bridge_if.sv
// rtl/cpu_axi_bridge_if.sv - AXI3 single-master bus bundle used by the bridge
//
// Purpose: groups the AR/R/AW/W/B channels of the bridge's AXI3 master port.
// Modports: master (bridge side, drives addresses/data/ready-for-responses),
//           slave  (interconnect side, drives readies and responses).
interface cpu_axi_bridge_if;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/axi_wr_tracker.sv
// rtl/axi_wr_tracker.sv - tracks the independent AW and W handshakes of one write
//
// Purpose: while active, drives awvalid/wvalid and remembers which of the two
// handshakes has completed; done rises in the cycle the second one completes.
// Ports: clk, rst (async, active-high); active (bridge is in the AW/W phase);
//        awready/wready (from slave); awvalid/wvalid (to slave); done (to FSM).
module axi_wr_tracker (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic awready,
  input  logic wready,
  output logic awvalid,
  output logic wvalid,
  output logic done
);

  logic aw_done;
  logic w_done;
  logic aw_fin;
  logic w_fin;

  assign awvalid = active && !aw_done;
  assign wvalid  = active && !w_done;

  // Count a handshake happening this cycle as already complete, so that
  // simultaneous AW/W acceptance leaves the phase after a single cycle.
  assign aw_fin = aw_done || (awvalid && awready);
  assign w_fin  = w_done  || (wvalid  && wready);
  assign done   = active && aw_fin && w_fin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (!active || done) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      aw_done <= aw_fin;
      w_done  <= w_fin;
    end
  end

endmodule

// File: rtl/cpu_axi_bridge.sv
// rtl/cpu_axi_bridge.sv - SRAM-like inst/data ports to a single AXI3 master
//
// Purpose: arbitrates instruction and data requests (data first), keeps one
// transaction in flight, issues it as a single-beat AXI read or write and
// returns a registered one-cycle data_ok pulse to the owning requester.
// Ports: clk, rst (async, active-high);
//        inst_req/inst_addr -> inst_addr_ok/inst_data_ok/inst_rdata;
//        data_req/wr/size/wstrb/addr/wdata -> data_addr_ok/data_data_ok/data_rdata;
//        axi: AXI3 master bundle (cpu_axi_bridge_if.master).
module cpu_axi_bridge
  import cpu_axi_pkg::*;
#(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_req,
  input  logic [31:0]      inst_addr,
  output logic             inst_addr_ok,
  output logic             inst_data_ok,
  output logic [31:0]      inst_rdata,
  input  logic             data_req,
  input  logic             data_wr,
  input  logic [1:0]       data_size,
  input  logic [3:0]       data_wstrb,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_wdata,
  output logic             data_addr_ok,
  output logic             data_data_ok,
  output logic [31:0]      data_rdata,
  cpu_axi_bridge_if.master axi
);

  state_t      state;
  state_t      state_nx;
  owner_t      owner_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  size_q;
  logic        rd_fire;
  logic        b_fire;
  logic        wr_done;
  logic        unused_ok;

  // Response IDs and status codes carry no information with one transaction
  // in flight, so they are deliberately ignored.
  assign unused_ok = ^{axi.rid, axi.rresp, axi.bid, axi.bresp};

  assign axi.arid    = (owner_q == OWN_DATA) ? DATA_ID : INST_ID;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = LEN_SINGLE;
  assign axi.arsize  = axi_size(size_q);
  assign axi.arburst = BURST_INCR;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;

  assign axi.awid    = DATA_ID;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = LEN_SINGLE;
  assign axi.awsize  = axi_size(size_q);
  assign axi.awburst = BURST_INCR;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'b0000;
  assign axi.awprot  = 3'b000;

  assign axi.wid     = DATA_ID;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = 1'b1;

  axi_wr_tracker u_wr_tracker (
    .clk     (clk),
    .rst     (rst),
    .active  (state == WR_AW_W),
    .awready (axi.awready),
    .wready  (axi.wready),
    .awvalid (axi.awvalid),
    .wvalid  (axi.wvalid),
    .done    (wr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    axi.arvalid  = 1'b0;
    axi.rready   = 1'b0;
    axi.bready   = 1'b0;
    rd_fire      = 1'b0;
    b_fire       = 1'b0;
    case (state)
      IDLE: begin
        // addr_ok is combinational from req; keep it quiet while reset holds.
        if (!rst) begin
          if (data_req) begin
            data_addr_ok = 1'b1;
            state_nx     = data_wr ? WR_AW_W : RD_AR;
          end else if (inst_req) begin
            inst_addr_ok = 1'b1;
            state_nx     = RD_AR;
          end
        end
      end
      RD_AR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) state_nx = RD_R;
      end
      RD_R: begin
        axi.rready = 1'b1;
        if (axi.rvalid && axi.rlast) begin
          rd_fire  = 1'b1;
          state_nx = IDLE;
        end
      end
      WR_AW_W: begin
        if (wr_done) state_nx = WR_B;
      end
      WR_B: begin
        axi.bready = 1'b1;
        if (axi.bvalid) begin
          b_fire   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q      <= OWN_INST;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      size_q       <= 2'd0;
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      inst_rdata   <= 32'd0;
      data_rdata   <= 32'd0;
    end else begin
      if (data_addr_ok) begin
        owner_q <= OWN_DATA;
        addr_q  <= data_addr;
        wdata_q <= data_wdata;
        wstrb_q <= data_wstrb;
        size_q  <= data_size;
      end else if (inst_addr_ok) begin
        owner_q <= OWN_INST;
        addr_q  <= inst_addr;
        size_q  <= SIZE_WORD;
      end
      // Completion is registered so data_ok lands on the first IDLE cycle.
      inst_data_ok <= rd_fire && (owner_q == OWN_INST);
      data_data_ok <= (rd_fire && (owner_q == OWN_DATA)) || b_fire;
      if (rd_fire && (owner_q == OWN_INST)) inst_rdata <= axi.rdata;
      if (rd_fire && (owner_q == OWN_DATA)) data_rdata <= axi.rdata;
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb/tb_cpu_axi_bridge.sv - scoreboard bench for cpu_axi_bridge
module tb_cpu_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  cpu_axi_bridge_if axi ();

  cpu_axi_bridge #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .axi          (axi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_inst;
    logic        chk_rd;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   inst_acc_cyc = 0;
  int   data_acc_cyc = 0;
  int   last_ok_cyc = 0;
  int   last_data_ok_cyc = 0;
  int   awcyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a data_ok pulse is presented.
  initial begin
    exp_t e;
    logic prev_ok;
    prev_ok = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ok = 1'b0;
      end else begin
        if (inst_data_ok || data_data_ok) begin
          chk("ok_pulse_width", {31'd0, prev_ok}, 32'd0);
          chk("ok_exclusive", {31'd0, inst_data_ok & data_data_ok}, 32'd0);
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ok: got inst=%0b data=%0b want none", inst_data_ok, data_data_ok);
          end else begin
            e = sb.pop_front();
            chk("ok_owner", {31'd0, inst_data_ok}, {31'd0, e.is_inst});
            if (e.chk_rd) chk("rdata", e.is_inst ? inst_rdata : data_rdata, e.rd);
          end
          last_ok_cyc = cyc;
          if (data_data_ok) last_data_ok_cyc = cyc;
        end
        prev_ok = inst_data_ok | data_data_ok;
      end
    end
  end

  task automatic req_inst(input logic [31:0] a, input logic [31:0] exp_rd);
    int n = 0;
    inst_req  = 1'b1;
    inst_addr = a;
    @(negedge clk);
    while (!inst_addr_ok && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("inst_accept", {31'd0, inst_addr_ok}, 32'd1);
    inst_acc_cyc = cyc;
    if (inst_addr_ok) sb.push_back('{1'b1, 1'b1, exp_rd});
    @(posedge clk);
    #1 inst_req = 1'b0;
  endtask

  task automatic req_data(input logic wr, input logic [1:0] sz, input logic [3:0] strb,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd);
    int n = 0;
    data_req   = 1'b1;
    data_wr    = wr;
    data_size  = sz;
    data_wstrb = strb;
    data_addr  = a;
    data_wdata = wd;
    @(negedge clk);
    while (!data_addr_ok && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("data_accept", {31'd0, data_addr_ok}, 32'd1);
    data_acc_cyc = cyc;
    if (data_addr_ok) sb.push_back('{1'b0, !wr, exp_rd});
    @(posedge clk);
    #1 data_req = 1'b0;
  endtask

  task automatic rd_slave(input int ar_wait, input int r_wait, input logic [31:0] rd,
                          input logic [31:0] ea, input logic [3:0] eid, input logic [2:0] esz);
    int n = 0;
    @(negedge clk);
    while (!axi.arvalid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ar_seen", {31'd0, axi.arvalid}, 32'd1);
    chk("araddr", axi.araddr, ea);
    chk("arid", {28'd0, axi.arid}, {28'd0, eid});
    chk("arsize", {29'd0, axi.arsize}, {29'd0, esz});
    chk("arlen_burst", {26'd0, axi.arlen, axi.arburst}, 32'h1);
    chk("ar_lock_cache_prot", {23'd0, axi.arlock, axi.arcache, axi.arprot}, 32'd0);
    chk("ar_no_aw", {31'd0, axi.awvalid | axi.wvalid}, 32'd0);
    for (int i = 0; i < ar_wait; i++) begin
      @(negedge clk);
      chk("ar_hold_valid", {31'd0, axi.arvalid}, 32'd1);
      chk("ar_hold_addr", axi.araddr, ea);
      chk("ar_hold_id", {28'd0, axi.arid}, {28'd0, eid});
    end
    axi.arready = 1'b1;
    @(posedge clk);
    #1 axi.arready = 1'b0;
    for (int i = 0; i < r_wait; i++) begin
      @(negedge clk);
      chk("ar_dropped", {31'd0, axi.arvalid}, 32'd0);
      chk("rready_wait", {31'd0, axi.rready}, 32'd1);
      @(posedge clk);
      #1;
    end
    axi.rvalid = 1'b1;
    axi.rlast  = 1'b1;
    axi.rdata  = rd;
    axi.rid    = eid;
    @(negedge clk);
    chk("rready", {31'd0, axi.rready}, 32'd1);
    @(posedge clk);
    #1;
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    axi.rdata  = 32'd0;
  endtask

  task automatic wr_slave(input int aw_wait, input int w_wait, input int b_wait,
                          input logic [31:0] ea, input logic [2:0] esz, input logic [3:0] estrb,
                          input logic [31:0] ed, output int cycles);
    int   n = 0;
    int   c = 0;
    logic aw_got = 1'b0;
    logic w_got = 1'b0;
    logic aw_hs;
    logic w_hs;
    @(negedge clk);
    while (!axi.awvalid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("aw_seen", {31'd0, axi.awvalid}, 32'd1);
    chk("awaddr", axi.awaddr, ea);
    chk("awsize", {29'd0, axi.awsize}, {29'd0, esz});
    chk("awid_wid", {24'd0, axi.awid, axi.wid}, 32'h11);
    chk("awlen_burst", {26'd0, axi.awlen, axi.awburst}, 32'h1);
    chk("wstrb", {28'd0, axi.wstrb}, {28'd0, estrb});
    chk("wdata", axi.wdata, ed);
    chk("wlast", {31'd0, axi.wlast}, 32'd1);
    while (!(aw_got && w_got) && c < 100) begin
      chk("awvalid_state", {31'd0, axi.awvalid}, {31'd0, !aw_got});
      chk("wvalid_state", {31'd0, axi.wvalid}, {31'd0, !w_got});
      chk("wr_no_ar", {31'd0, axi.arvalid}, 32'd0);
      axi.awready = (c >= aw_wait) && !aw_got;
      axi.wready  = (c >= w_wait) && !w_got;
      aw_hs = axi.awvalid && axi.awready;
      w_hs  = axi.wvalid && axi.wready;
      @(posedge clk);
      #1;
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      aw_got = aw_got | aw_hs;
      w_got  = w_got | w_hs;
      c++;
      @(negedge clk);
    end
    cycles = c;
    for (int i = 0; i < b_wait; i++) begin
      chk("bready_wait", {31'd0, axi.bready}, 32'd1);
      chk("aw_w_dropped", {30'd0, axi.awvalid, axi.wvalid}, 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    axi.bvalid = 1'b1;
    axi.bid    = 4'd1;
    chk("bready", {31'd0, axi.bready}, 32'd1);
    chk("b_no_ar", {31'd0, axi.arvalid}, 32'd0);
    @(posedge clk);
    #1 axi.bvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    inst_req = 1'b1;
    inst_addr = 32'd0;
    data_req = 1'b1;
    data_wr = 1'b0;
    data_size = 2'd0;
    data_wstrb = 4'd0;
    data_addr = 32'd0;
    data_wdata = 32'd0;
    axi.arready = 1'b0;
    axi.rid = 4'd0;
    axi.rdata = 32'd0;
    axi.rresp = 2'd0;
    axi.rlast = 1'b0;
    axi.rvalid = 1'b0;
    axi.awready = 1'b0;
    axi.wready = 1'b0;
    axi.bid = 4'd0;
    axi.bresp = 2'd0;
    axi.bvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    chk("rst_valids", {29'd0, axi.arvalid, axi.awvalid, axi.wvalid}, 32'd0);
    chk("rst_readies", {30'd0, axi.rready, axi.bready}, 32'd0);
    chk("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    chk("rst_inst_rdata", inst_rdata, 32'd0);
    chk("rst_data_rdata", data_rdata, 32'd0);
    chk("rst_araddr", axi.araddr, 32'd0);
    inst_req = 1'b0;
    data_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Single zero-wait instruction fetch.
    fork
      req_inst(32'hBFC00000, 32'h3C010001);
      rd_slave(0, 0, 32'h3C010001, 32'hBFC00000, 4'd0, 3'd2);
    join
    drain("t1_drain");
    chk("t1_latency", last_ok_cyc - inst_acc_cyc, 32'd3);

    // Simultaneous requests: data wins, inst accepted on data_ok cycle.
    fork
      req_data(1'b0, 2'd2, 4'hF, 32'h80000010, 32'd0, 32'h11223344);
      req_inst(32'hBFC00004, 32'h24020005);
      begin
        @(negedge clk);
        chk("t2_data_first", {31'd0, data_addr_ok}, 32'd1);
        chk("t2_inst_blocked", {31'd0, inst_addr_ok}, 32'd0);
      end
      begin
        rd_slave(0, 0, 32'h11223344, 32'h80000010, 4'd1, 3'd2);
        rd_slave(0, 0, 32'h24020005, 32'hBFC00004, 4'd0, 3'd2);
      end
    join
    drain("t2_drain");
    chk("t2_inst_on_data_ok", inst_acc_cyc, last_data_ok_cyc);
    chk("t2_data_rdata_hold", data_rdata, 32'h11223344);
    chk("t2_inst_rdata_hold", inst_rdata, 32'h24020005);

    // Byte store, awready two cycles late, wready immediate.
    fork
      req_data(1'b1, 2'd0, 4'b1000, 32'h80000003, 32'hAB000000, 32'd0);
      wr_slave(2, 0, 0, 32'h80000003, 3'd0, 4'b1000, 32'hAB000000, awcyc);
    join
    drain("t3_drain");
    chk("t3_aw_w_cycles", awcyc, 32'd3);
    chk("t3_data_rdata_hold", data_rdata, 32'h11223344);

    // Word store with AW and W accepted together.
    fork
      req_data(1'b1, 2'd2, 4'hF, 32'h80000100, 32'hDEADBEEF, 32'd0);
      wr_slave(0, 0, 1, 32'h80000100, 3'd2, 4'hF, 32'hDEADBEEF, awcyc);
    join
    drain("t4_drain");
    chk("t4_aw_w_cycles", awcyc, 32'd1);

    // Halfword read with arready 5 late and rvalid 3 more after that.
    fork
      req_data(1'b0, 2'd1, 4'h0, 32'h80000202, 32'd0, 32'h5A5A1234);
      rd_slave(5, 3, 32'h5A5A1234, 32'h80000202, 4'd1, 3'd1);
    join
    drain("t5_drain");
    chk("t5_latency", last_ok_cyc - data_acc_cyc, 32'd11);

    // Reset while waiting in RD_R.
    fork
      req_inst(32'hBFC00010, 32'hFFFFFFFF);
      begin
        int n = 0;
        @(negedge clk);
        while (!axi.arvalid && n < 200) begin
          @(negedge clk);
          n++;
        end
        chk("t6_ar_seen", {31'd0, axi.arvalid}, 32'd1);
        axi.arready = 1'b1;
        @(posedge clk);
        #1 axi.arready = 1'b0;
      end
    join
    chk("t6_in_rd_r", {31'd0, axi.rready}, 32'd1);
    inst_req = 1'b1;
    rst = 1'b1;
    #1;
    sb.delete();
    chk("t6_rst_readies", {30'd0, axi.rready, axi.bready}, 32'd0);
    chk("t6_rst_valids", {29'd0, axi.arvalid, axi.awvalid, axi.wvalid}, 32'd0);
    chk("t6_rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    chk("t6_rst_inst_rdata", inst_rdata, 32'd0);
    chk("t6_rst_data_rdata", data_rdata, 32'd0);
    @(posedge clk);
    #1;
    inst_req = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_no_ok_after_rst", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    end
    @(posedge clk);
    #1;
    fork
      req_inst(32'hBFC00020, 32'h8C080000);
      rd_slave(0, 0, 32'h8C080000, 32'hBFC00020, 4'd0, 3'd2);
    join
    drain("t6_drain");
    chk("t6_latency", last_ok_cyc - inst_acc_cyc, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
